// File: rtl/apb_bridge_mc_if.sv
// Core-side data-memory port plus multi-slave APB bus, bundled for apb_bridge_mc.
// The bridge connects through the master modport; the core and peripherals
// (or a testbench) connect through the slave modport.
interface apb_bridge_mc_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic [ADDR_W-1:0]         rv_addr;
  logic [DATA_W-1:0]         rv_wdata;
  logic [DATA_W/8-1:0]       rv_wstrb;
  logic                      rv_mem_write;
  logic                      rv_mem_read;
  logic [DATA_W-1:0]         rv_rdata;
  logic                      rv_err;
  logic                      cpu_stall;
  logic [NUM_SLV-1:0]        PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic [DATA_W/8-1:0]       PSTRB;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;

  modport master (
    input  rv_addr, rv_wdata, rv_wstrb, rv_mem_write, rv_mem_read,
    output rv_rdata, rv_err, cpu_stall,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output rv_addr, rv_wdata, rv_wstrb, rv_mem_write, rv_mem_read,
    input  rv_rdata, rv_err, cpu_stall,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_bridge_mc.sv
// Multi-slave APB bridge for the core data-memory port.
// Decodes the peripheral window and slave index, runs SETUP/ACCESS, returns
// PSLVERR or decode errors, and stalls the core until the access retires.
// Optional feature: define APB_TIMEOUT_EN to add an ACCESS-phase watchdog.
module apb_bridge_mc #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h4000_0000,
  parameter logic [ADDR_W-1:0] BASE_MASK   = 32'hFFFF_0000,
  parameter int                SEL_LSB     = 12,
  parameter int                TIMEOUT_CYC = 255
) (
  input logic            clk,
  input logic            rst,
  apb_bridge_mc_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  // The select field is decoded at the full 16-slave width so that indices
  // beyond NUM_SLV (e.g. 5 with four slaves) are caught as decode errors
  // instead of aliasing onto a real slave.
  localparam int            DEC_W = 4;
  localparam logic [DEC_W:0] NSLV = (DEC_W+1)'(NUM_SLV);

  if ((DATA_W % 8) != 0 || NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("apb_bridge_mc: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t              r_state, w_nxt;
  logic [NUM_SLV-1:0]  r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic [DEC_W-1:0]    w_dec_idx;
  logic                w_dec_ok;
  logic                w_hit;
  logic                w_req;
  logic                w_stall;
  logic                w_timeout;
  logic [NUM_SLV-1:0]  w_onehot;
  logic                w_sel_rdy;
  logic                w_sel_err;
  logic [DATA_W-1:0]   w_sel_rdata;

  assign w_dec_idx = bus.rv_addr[SEL_LSB +: DEC_W];
  assign w_dec_ok  = ({1'b0, w_dec_idx} < NSLV);
  assign w_hit     = ((bus.rv_addr & BASE_MASK) == (BASE_ADDR & BASE_MASK));
  assign w_req     = w_hit && (bus.rv_mem_read || bus.rv_mem_write);

  // Slave select decode and response mux for the latched slave index.
  always_comb begin
    w_onehot    = '0;
    w_sel_rdy   = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      w_onehot[i] = (w_dec_idx == DEC_W'(i));
      if (r_idx == IDX_W'(i)) begin
        w_sel_rdy   = bus.PREADY[i];
        w_sel_err   = bus.PSLVERR[i];
        w_sel_rdata = bus.PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int                TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] r_to_cnt;

  // Watchdog: counts ACCESS cycles without PREADY, cleared on SETUP entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_to_cnt <= '0;
    else if (w_nxt == S_SETUP)                 r_to_cnt <= '0;
    else if (r_state == S_ACCESS && !w_sel_rdy) r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Abort on the ACCESS cycle whose increment would reach TIMEOUT_CYC.
  assign w_timeout = (r_state == S_ACCESS) && !w_sel_rdy && (r_to_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // Next-state decode and combinational core stall.
  always_comb begin
    w_nxt   = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_req;
        if (w_req) w_nxt = w_dec_ok ? S_SETUP : S_DONE;
      end
      S_SETUP: begin
        w_stall = 1'b1;
        w_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        w_stall = 1'b1;
        if (w_sel_rdy || w_timeout) w_nxt = S_DONE;
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // APB request capture, phase control and completion results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_idx     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_dec_ok) begin
              r_paddr  <= bus.rv_addr;
              r_pwdata <= bus.rv_wdata;
              r_pwrite <= bus.rv_mem_write;
              r_pstrb  <= bus.rv_mem_write ? bus.rv_wstrb : '0;
              r_idx    <= w_dec_idx[IDX_W-1:0];
              r_psel   <= w_onehot;
            end else begin
              r_err   <= 1'b1;
              r_rdata <= '0;
            end
          end
        end
        S_SETUP: r_penable <= 1'b1;
        S_ACCESS: begin
          if (w_sel_rdy) begin
            r_err     <= w_sel_err;
            if (!r_pwrite) r_rdata <= w_sel_rdata;
            r_psel    <= '0;
            r_penable <= 1'b0;
          end else if (w_timeout) begin
            r_err     <= 1'b1;
            r_rdata   <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.PSTRB     = r_pstrb;
  assign bus.rv_rdata  = r_rdata;
  assign bus.rv_err    = r_err;
  assign bus.cpu_stall = w_stall;
endmodule

// File: tb/tb_apb_bridge_mc.sv
// Self-checking bench for apb_bridge_mc (four slaves, TIMEOUT_CYC=8).
module tb_apb_bridge_mc;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_bridge_mc_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) bus ();

  apb_bridge_mc #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Slave model: every selected slave is ready after cfg_wait low cycles.
  int          cfg_wait = 0;
  bit          cfg_err  = 1'b0;
  logic [31:0] slv_rdata [4];
  int          acc_cnt  = 0;

  always @(posedge clk) begin
    if (bus.PENABLE) acc_cnt <= acc_cnt + 1;
    else             acc_cnt <= 0;
  end

  always_comb begin
    bus.PREADY = (bus.PENABLE && acc_cnt >= cfg_wait) ? bus.PSEL : 4'b0;
    bus.PSLVERR = cfg_err ? bus.PREADY : 4'b0;
    for (int i = 0; i < 4; i++) bus.PRDATA[i*32 +: 32] = slv_rdata[i];
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stall;
    bit          ok;
    logic [3:0]  psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] m_rdata = '0;
  logic        m_err   = 1'b0;

  task automatic apply_reset();
    rst = 1'b1;
    bus.rv_mem_read  = 1'b0;
    bus.rv_mem_write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_rdata = '0;
    m_err   = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input bit wr, input bit rd,
                         input int wt, input bit serr);
    exp_t e, got;
    int   idx, cyc;
    bit   stable, timed_out;
    logic [3:0]  psel1, psel_or;
    logic [31:0] paddr1, pwdata1;
    logic [3:0]  pstrb1;
    logic        pwrite1, pen1, pen2;
    idx = int'(addr[15:12]);
    e.ok = (idx < 4);
    timed_out = 1'b0;
`ifdef APB_TIMEOUT_EN
    timed_out = e.ok && (wt >= TO);
`endif
    if (!e.ok) begin
      e.stall = 1; e.err = 1'b1; e.rdata = '0;
    end else if (timed_out) begin
      e.stall = 2 + TO; e.err = 1'b1; e.rdata = '0;
    end else begin
      e.stall = 3 + wt; e.err = serr;
      e.rdata = wr ? m_rdata : slv_rdata[idx];
    end
    e.psel   = e.ok ? 4'(1 << idx) : 4'b0;
    e.paddr  = addr;
    e.pwrite = wr;
    e.pstrb  = wr ? wstrb : 4'b0;
    e.pwdata = wdata;
    m_rdata  = e.rdata;
    m_err    = e.err;
    exp_q.push_back(e);

    cfg_wait = wt;
    cfg_err  = serr;
    @(negedge clk);
    bus.rv_addr = addr; bus.rv_wdata = wdata; bus.rv_wstrb = wstrb;
    bus.rv_mem_write = wr; bus.rv_mem_read = rd;
    #1;
    cyc = 0; stable = 1'b1; psel_or = '0;
    psel1 = '0; paddr1 = '0; pwdata1 = '0; pstrb1 = '0; pwrite1 = 1'b0; pen1 = 1'b0; pen2 = 1'b0;
    while (bus.cpu_stall && cyc < 200) begin
      if (cyc == 1) begin
        psel1 = bus.PSEL; paddr1 = bus.PADDR; pwdata1 = bus.PWDATA;
        pstrb1 = bus.PSTRB; pwrite1 = bus.PWRITE; pen1 = bus.PENABLE;
      end
      if (cyc == 2) pen2 = bus.PENABLE;
      if (cyc >= 1) begin
        psel_or |= bus.PSEL;
        if (bus.PSEL !== psel1 || bus.PADDR !== paddr1 || bus.PWDATA !== pwdata1 ||
            bus.PSTRB !== pstrb1 || bus.PWRITE !== pwrite1) stable = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end

    got = exp_q.pop_front();
    check("stall_cycles", 64'(cyc), 64'(got.stall));
    check("rv_err", 64'(bus.rv_err), 64'(got.err));
    check("rv_rdata", 64'(bus.rv_rdata), 64'(got.rdata));
    if (got.ok) begin
      check("psel_setup", 64'(psel1), 64'(got.psel));
      check("penable_setup", 64'(pen1), 64'd0);
      check("penable_access", 64'(pen2), 64'd1);
      check("paddr", 64'(paddr1), 64'(got.paddr));
      check("pwrite", 64'(pwrite1), 64'(got.pwrite));
      check("pstrb", 64'(pstrb1), 64'(got.pstrb));
      if (got.pwrite) check("pwdata", 64'(pwdata1), 64'(got.pwdata));
      check("bus_stable", 64'(stable), 64'd1);
    end else begin
      check("psel_never", 64'(psel_or), 64'd0);
    end
    if (cyc >= 200) apply_reset();
    bus.rv_mem_read  = 1'b0;
    bus.rv_mem_write = 1'b0;
    @(negedge clk);
    check("idle_psel", 64'(bus.PSEL), 64'd0);
  endtask

  task automatic run_nowin(input logic [31:0] addr);
    logic [3:0] psel_or;
    logic       pen_or, stall_or;
    @(negedge clk);
    bus.rv_addr = addr; bus.rv_mem_read = 1'b1; bus.rv_mem_write = 1'b0;
    #1;
    psel_or = '0; pen_or = 1'b0; stall_or = 1'b0;
    for (int i = 0; i < 3; i++) begin
      psel_or |= bus.PSEL; pen_or |= bus.PENABLE; stall_or |= bus.cpu_stall;
      @(negedge clk);
    end
    check("nowin_stall", 64'(stall_or), 64'd0);
    check("nowin_psel", 64'(psel_or), 64'd0);
    check("nowin_penable", 64'(pen_or), 64'd0);
    check("nowin_err_hold", 64'(bus.rv_err), 64'(m_err));
    check("nowin_rdata_hold", 64'(bus.rv_rdata), 64'(m_rdata));
    bus.rv_mem_read = 1'b0;
  endtask

  initial begin
    bus.rv_addr = '0; bus.rv_wdata = '0; bus.rv_wstrb = '0;
    bus.rv_mem_read = 1'b0; bus.rv_mem_write = 1'b0;
    for (int i = 0; i < 4; i++) slv_rdata[i] = 32'h1111_0000 * (i + 1);
    #1;
    check("rst_psel", 64'(bus.PSEL), 64'd0);
    check("rst_penable", 64'(bus.PENABLE), 64'd0);
    check("rst_err", 64'(bus.rv_err), 64'd0);
    check("rst_rdata", 64'(bus.rv_rdata), 64'd0);
    check("rst_stall", 64'(bus.cpu_stall), 64'd0);
    apply_reset();

    // Directed cases.
    slv_rdata[2] = 32'h1234_5678;
    run_txn(32'h4000_2004, 32'h0, 4'hF, 1'b0, 1'b1, 0, 1'b0);
    run_txn(32'h4000_1000, 32'hA5A5_A5A5, 4'b0011, 1'b1, 1'b0, 3, 1'b0);
    slv_rdata[0] = 32'hDEAD_BEEF;
    run_txn(32'h4000_0010, 32'h0, 4'h0, 1'b0, 1'b1, 1, 1'b1);
    run_txn(32'h4000_3008, 32'h0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    run_txn(32'h4000_5000, 32'h0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    run_txn(32'h4000_0000, 32'h0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    run_txn(32'h4000_1004, 32'h0F0F_0F0F, 4'b1100, 1'b1, 1'b1, 0, 1'b0);
    run_nowin(32'h2000_0000);

    // Random mix, including decode errors and slave errors.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      bit w;
      for (int i = 0; i < 4; i++) slv_rdata[i] = $urandom;
      a = 32'h4000_0000 | (32'($urandom_range(0, 5)) << 12) | (32'($urandom_range(0, 255)) << 2);
      w = 1'($urandom_range(0, 1));
      run_txn(a, $urandom, 4'($urandom_range(0, 15)), w, !w, $urandom_range(0, 3),
              1'($urandom_range(0, 3) == 0));
    end

`ifdef APB_TIMEOUT_EN
    run_txn(32'h4000_3000, 32'h0, 4'h0, 1'b0, 1'b1, 1000, 1'b0);
    run_txn(32'h4000_2000, 32'h0, 4'h0, 1'b0, 1'b1, TO - 1, 1'b0);
`endif

    // Hung access, then reset in ACCESS.
    cfg_wait = 1000; cfg_err = 1'b0;
    @(negedge clk);
    bus.rv_addr = 32'h4000_1000; bus.rv_mem_read = 1'b1; bus.rv_mem_write = 1'b0;
`ifdef APB_TIMEOUT_EN
    repeat (4) @(negedge clk);
`else
    repeat (40) @(negedge clk);
    check("hang_stall", 64'(bus.cpu_stall), 64'd1);
`endif
    check("hang_penable", 64'(bus.PENABLE), 64'd1);
    rst = 1'b1;
    bus.rv_mem_read = 1'b0;
    #1;
    check("arst_psel", 64'(bus.PSEL), 64'd0);
    check("arst_penable", 64'(bus.PENABLE), 64'd0);
    check("arst_paddr", 64'(bus.PADDR), 64'd0);
    check("arst_pwdata", 64'(bus.PWDATA), 64'd0);
    check("arst_rdata", 64'(bus.rv_rdata), 64'd0);
    check("arst_err", 64'(bus.rv_err), 64'd0);
    check("arst_stall", 64'(bus.cpu_stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_rdata = '0; m_err = 1'b0;
    slv_rdata[3] = 32'hCAFE_F00D;
    run_txn(32'h4000_3000, 32'h0, 4'h0, 1'b0, 1'b1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
